// File: rtl/fft_input_framer.sv
// Ping-pong input framer for the FFT: fills one bank in natural order while
// the other bank drains in bit-reversed order through a registered output stage.
module fft_input_framer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOG2N      = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic                  oReady,
  output logic                  oValid,
  output logic [DATA_WIDTH-1:0] oData,
  output logic [LOG2N-1:0]      oIndex,
  output logic                  oLast,
  input  logic                  iReady
);

  localparam int unsigned N = 1 << LOG2N;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r[i] = x[int'(LOG2N) - 1 - i];
    end
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [2][N];

  logic                  wbank_q, wbank_d;
  logic [LOG2N-1:0]      wcnt_q,  wcnt_d;
  logic                  rbank_q, rbank_d;
  logic [LOG2N-1:0]      rcnt_q,  rcnt_d;
  logic [1:0]            full_q,  full_d;
  logic                  valid_q, valid_d;
  logic                  last_q,  last_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [LOG2N-1:0]      index_q, index_d;

  logic                  accept;
  logic                  load;
  logic [LOG2N-1:0]      rd_addr;

  // Write side may only target a bank the read side has released.
  assign oReady  = !Reset && !full_q[wbank_q];
  assign accept  = iValid && oReady;
  assign load    = full_q[rbank_q] && (!valid_q || iReady);
  assign rd_addr = bitrev(rcnt_q);

  // Next-state logic for both bank pointers and the output stage.
  always_comb begin
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    rbank_d = rbank_q;
    rcnt_d  = rcnt_q;
    full_d  = full_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    index_d = index_q;

    if (accept) begin
      wcnt_d = wcnt_q + LOG2N'(1);
      if (&wcnt_q) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end

    // Full set above and full clear here always hit different banks.
    if (load) begin
      data_d  = mem_q[rbank_q][rd_addr];
      index_d = rd_addr;
      last_d  = &rcnt_q;
      valid_d = 1'b1;
      rcnt_d  = rcnt_q + LOG2N'(1);
      if (&rcnt_q) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end else if (iReady) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wbank_q <= 1'b0;
      wcnt_q  <= '0;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
      full_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

  // Sample storage is deliberately left unreset.
  always_ff @(posedge Clock) begin
    if (accept) begin
      mem_q[wbank_q][wcnt_q] <= iData;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;
  assign oIndex = index_q;
  assign oLast  = last_q;

endmodule
